// File: rtl/aes_pkg.sv
// Shared AES byte/word types and GF(2^8) helpers used by the MixColumns datapath.
package aes_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    // Low byte of the field polynomial x^8+x^4+x^3+x+1.
    localparam byte_t RED_POLY = 8'h1B;

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? RED_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column, row 0 in bits 31:24.
module mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    input  logic        i_inv,
    output logic [31:0] o_col
);

    // One output row; callers rotate the operands so p is the diagonal element.
    function automatic byte_t mix_row(input byte_t p, input byte_t q,
                                      input byte_t s, input byte_t t,
                                      input logic inv);
        byte_t p2, p4, p8, q2, q4, q8, s2, s4, s8, t2, t4, t8;
        byte_t res;
        p2 = xtime(p); p4 = xtime(p2); p8 = xtime(p4);
        q2 = xtime(q); q4 = xtime(q2); q8 = xtime(q4);
        s2 = xtime(s); s4 = xtime(s2); s8 = xtime(s4);
        t2 = xtime(t); t4 = xtime(t2); t8 = xtime(t4);
        if (inv) begin
            // 0e.p ^ 0b.q ^ 0d.s ^ 09.t
            res = (p8 ^ p4 ^ p2) ^ (q8 ^ q2 ^ q) ^ (s8 ^ s4 ^ s) ^ (t8 ^ t);
        end else begin
            // 02.p ^ 03.q ^ s ^ t
            res = p2 ^ (q2 ^ q) ^ s ^ t;
        end
        return res;
    endfunction

    byte_t a0, a1, a2, a3;

    always_comb begin
        a0 = i_col[31:24];
        a1 = i_col[23:16];
        a2 = i_col[15:8];
        a3 = i_col[7:0];
        o_col = {mix_row(a0, a1, a2, a3, i_inv),
                 mix_row(a1, a2, a3, a0, i_inv),
                 mix_row(a2, a3, a0, a1, i_inv),
                 mix_row(a3, a0, a1, a2, i_inv)};
    end

endmodule

// File: rtl/mix_columns.sv
// Registered AES (Inv)MixColumns over the full 128-bit state, one state per cycle.
// Handshake: i_valid qualifies i_state/i_inv for the current edge; o_valid marks a
// fresh o_state for exactly one cycle. There is no ready; the consumer must take it.
module mix_columns
    import aes_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    input  logic         i_inv,
    input  logic [127:0] i_state,
    output logic         o_valid,
    output logic [127:0] o_state
);

    logic [127:0] mixed;

    for (genvar c = 0; c < 4; c++) begin : g_col
        mix_single_column u_col (
            .i_col (i_state[127-32*c -: 32]),
            .i_inv (i_inv),
            .o_col (mixed[127-32*c -: 32])
        );
    end

    // o_state holds the last result while idle; only o_valid drops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_state <= 128'h0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_state <= mixed;
            end
        end
    end

endmodule

// File: tb/tb_mix_columns.sv
// Directed self-checking bench for mix_columns with hand-computed AES vectors.
module tb_mix_columns;

    logic         i_clk;
    logic         i_rst;
    logic         i_valid;
    logic         i_inv;
    logic [127:0] i_state;
    logic         o_valid;
    logic [127:0] o_state;

    int n_cmp;
    int n_bad;

    localparam logic [127:0] V1_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] V1_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] V2_IN  = 128'h49db873b453953897f02d2f177de961a;
    localparam logic [127:0] V2_OUT = 128'h584dcaf11b4b5aacdbe7caa81b6bb0e5;
    localparam logic [127:0] ONES_COL = 128'h01010101010101010101010101010101;
    localparam logic [127:0] ALL_FF   = {128{1'b1}};

    mix_columns dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .i_inv   (i_inv),
        .i_state (i_state),
        .o_valid (o_valid),
        .o_state (o_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic drive(input logic v, input logic inv, input logic [127:0] st);
        i_valid = v;
        i_inv   = inv;
        i_state = st;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] exp_state, input logic exp_valid);
        n_cmp++;
        assert (o_state === exp_state) else begin
            n_bad++;
            $error("FAIL %s o_state: got %h want %h", tag, o_state, exp_state);
        end
        n_cmp++;
        assert (o_valid === exp_valid) else begin
            n_bad++;
            $error("FAIL %s o_valid: got %b want %b", tag, o_valid, exp_valid);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        i_rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        #1;
        check("reset_async", 128'h0, 1'b0);
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;

        drive(1'b1, 1'b0, V1_IN);
        tick();
        check("fwd_v1", V1_OUT, 1'b1);

        drive(1'b0, 1'b1, V2_IN);
        tick();
        check("idle_hold", V1_OUT, 1'b0);

        drive(1'b1, 1'b0, V2_IN);
        tick();
        check("fwd_v2", V2_OUT, 1'b1);

        drive(1'b1, 1'b1, V1_OUT);
        tick();
        check("inv_v1", V1_IN, 1'b1);

        drive(1'b1, 1'b0, V1_IN);
        tick();
        check("b2b_first", V1_OUT, 1'b1);
        drive(1'b1, 1'b0, V2_IN);
        tick();
        check("b2b_second", V2_OUT, 1'b1);

        drive(1'b1, 1'b1, V1_OUT);
        tick();
        check("alt_inv", V1_IN, 1'b1);
        drive(1'b1, 1'b0, V1_IN);
        tick();
        check("alt_fwd", V1_OUT, 1'b1);

        drive(1'b1, 1'b0, ONES_COL);
        tick();
        check("fwd_ones", ONES_COL, 1'b1);
        drive(1'b1, 1'b0, ALL_FF);
        tick();
        check("fwd_ff", ALL_FF, 1'b1);
        drive(1'b1, 1'b0, 128'h0);
        tick();
        check("fwd_zero", 128'h0, 1'b1);
        drive(1'b1, 1'b1, ALL_FF);
        tick();
        check("inv_ff", ALL_FF, 1'b1);
        drive(1'b1, 1'b1, 128'h0);
        tick();
        check("inv_zero", 128'h0, 1'b1);

        // Reset mid-stream, asserted between edges while o_valid is high.
        drive(1'b1, 1'b0, V2_IN);
        tick();
        check("pre_reset", V2_OUT, 1'b1);
        drive(1'b1, 1'b0, V1_IN);
        #2 i_rst = 1'b1;
        #1;
        check("reset_mid", 128'h0, 1'b0);
        tick();
        check("reset_held", 128'h0, 1'b0);
        #2;
        i_rst = 1'b0;
        drive(1'b0, 1'b0, V1_IN);
        tick();
        check("post_reset_idle", 128'h0, 1'b0);
        drive(1'b1, 1'b0, V2_IN);
        tick();
        check("post_reset_v2", V2_OUT, 1'b1);
        drive(1'b0, 1'b0, '0);
        tick();
        check("post_reset_drop", V2_OUT, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
